// File: rtl/huc_bus_master_if.sv
// Core-request, MPR access and physical bus signals of the HuC6280 bus initiator.
// master = the initiator's view, slave = the core/responder side.
interface huc_bus_master_if;
  logic        req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        speed_hi;
  logic        mpr_we;
  logic [7:0]  mpr_mask;
  logic [7:0]  mpr_wdata;
  logic [7:0]  mpr_rsel;
  logic [7:0]  mpr_rdata;
  logic [20:0] addr;
  logic [7:0]  dOut;
  logic [7:0]  dIn;
  logic        re;
  logic        we;
  logic        CE_n;
  logic        CER_n;
  logic        CEK_n;
  logic        CE7_n;

  // Handshake: a request transfers on a rising edge where req & req_ready are both high;
  // the core holds req and its fields stable until then. rsp_valid is a one-cycle pulse
  // with no back-pressure, so the core must take rsp_rdata in the cycle it is high.
  modport master (
    input  req, req_we, req_addr, req_wdata, speed_hi,
    input  mpr_we, mpr_mask, mpr_wdata, mpr_rsel, dIn,
    output req_ready, rsp_valid, rsp_rdata, mpr_rdata,
    output addr, dOut, re, we, CE_n, CER_n, CEK_n, CE7_n
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, speed_hi,
    output mpr_we, mpr_mask, mpr_wdata, mpr_rsel, dIn,
    input  req_ready, rsp_valid, rsp_rdata, mpr_rdata,
    input  addr, dOut, re, we, CE_n, CER_n, CEK_n, CE7_n
  );
endinterface

// File: rtl/huc_bus_master.sv
// HuC6280 bus initiator: MPR page translation, chip-enable decode and wait-state timing.
// Optional macro HUC_VDC_WAIT_EN adds one wait cycle to every VDC (CEK_n) access.
module huc_bus_master #(
  parameter logic [7:0] RESET_MPR7 = 8'h00,
  parameter int         SLOW_WAIT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  huc_bus_master_if.master  bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mpr [8];
  logic [4:0]  r_wcnt;
  logic        r_is_wr;
  logic [20:0] r_addr;
  logic [7:0]  r_dout;
  logic        r_re;
  logic        r_we;
  logic        r_ce_n;
  logic        r_cer_n;
  logic        r_cek_n;
  logic        r_ce7_n;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;

  logic        w_accept;
  logic [7:0]  w_page;
  logic [12:0] w_off;
  logic        w_ce;
  logic        w_cer;
  logic        w_cek;
  logic        w_ce7;
  logic [4:0]  w_wcnt;
  logic [7:0]  w_mpr_rdata;

  assign bus.req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept      = bus.req && bus.req_ready;

  // Translation reads the MPRs as they stand before this edge's mpr_we takes effect.
  assign w_page = r_mpr[bus.req_addr[15:13]];
  assign w_off  = bus.req_addr[12:0];
  assign w_ce   = !w_page[7];
  assign w_cer  = (w_page[7:2] == 6'b111110);
  assign w_cek  = (w_page == 8'hFF) && (w_off[12:10] == 3'b000);
  assign w_ce7  = (w_page == 8'hFF) && (w_off[12:10] == 3'b001);

`ifdef HUC_VDC_WAIT_EN
  assign w_wcnt = (bus.speed_hi ? 5'd0 : 5'(SLOW_WAIT)) + {4'd0, w_cek};
`else
  assign w_wcnt = bus.speed_hi ? 5'd0 : 5'(SLOW_WAIT);
`endif

  always_comb begin
    w_mpr_rdata = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (bus.mpr_rsel[i]) w_mpr_rdata = w_mpr_rdata | r_mpr[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ACCESS;
      S_ACCESS:  if (r_wcnt == 5'd0) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) r_mpr[i] <= 8'h00;
      r_mpr[7]    <= RESET_MPR7;
      r_wcnt      <= 5'd0;
      r_is_wr     <= 1'b0;
      r_addr      <= 21'd0;
      r_dout      <= 8'h00;
      r_re        <= 1'b0;
      r_we        <= 1'b0;
      r_ce_n      <= 1'b1;
      r_cer_n     <= 1'b1;
      r_cek_n     <= 1'b1;
      r_ce7_n     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.mpr_we && bus.mpr_mask[i]) r_mpr[i] <= bus.mpr_wdata;
      end
      r_rsp_valid <= (r_state == S_CAPTURE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= {w_page, w_off};
            r_dout  <= bus.req_wdata;
            r_re    <= !bus.req_we;
            r_we    <= bus.req_we;
            r_is_wr <= bus.req_we;
            r_ce_n  <= !w_ce;
            r_cer_n <= !w_cer;
            r_cek_n <= !w_cek;
            r_ce7_n <= !w_ce7;
            r_wcnt  <= w_wcnt;
          end
        end
        S_ACCESS: begin
          if (r_wcnt == 5'd0) begin
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_ce_n  <= 1'b1;
            r_cer_n <= 1'b1;
            r_cek_n <= 1'b1;
            r_ce7_n <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - 5'd1;
          end
        end
        S_CAPTURE: begin
          if (!r_is_wr) r_rsp_rdata <= bus.dIn;
        end
        default: ;
      endcase
    end
  end

  assign bus.addr      = r_addr;
  assign bus.dOut      = r_dout;
  assign bus.re        = r_re;
  assign bus.we        = r_we;
  assign bus.CE_n      = r_ce_n;
  assign bus.CER_n     = r_cer_n;
  assign bus.CEK_n     = r_cek_n;
  assign bus.CE7_n     = r_ce7_n;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mpr_rdata = w_mpr_rdata;
  assign o_dbg_state   = r_state;

endmodule
